alpha_blend_engine: RTL and testbench

Parametrised successor to the fixed-geometry layer blender. Streams two source layer buffers out of SRAM one line (DATA_SIZE_WORDS pixels) at a time, combines them per colour channel, and writes the result to the output buffer. Adds configurable buffer bases and size, a programmable alpha scale with rounding, a blend mode select, optional colour-key transparency, and a ready-based SRAM handshake in place of fixed one-cycle latency. Sits between the layer renderers and the output-buffer scan-out, sharing the SRAM port with them.

---
 rtl/alpha_blend_engine_if.sv | 36 +++
 rtl/alpha_blend_engine.sv | 202 ++++++++++++++++++++
 tb/tb_alpha_blend_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alpha_blend_engine_if.sv
// alpha_blend_engine_if
// Line-wide SRAM request/response bus shared by the layer blender and the
// memory arbiter. The master issues one read or write request at a time and
// holds it until the slave answers with mem_ready.
interface alpha_blend_engine_if #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64
);
    localparam int LINE_BITS = 8 * WORD_SIZE_BYTES * DATA_SIZE_WORDS;

    logic                      read_enable;
    logic                      write_enable;
    logic [ADDR_SIZE_BITS-1:0] address;
    logic                      mem_ready;
    logic [LINE_BITS-1:0]      read_data;
    logic [LINE_BITS-1:0]      write_data;

    modport master (
        output read_enable,
        output write_enable,
        output address,
        output write_data,
        input  mem_ready,
        input  read_data
    );

    modport slave (
        input  read_enable,
        input  write_enable,
        input  address,
        input  write_data,
        output mem_ready,
        output read_data
    );
endinterface

// File: rtl/alpha_blend_engine.sv
// alpha_blend_engine
// Streams two layer buffers from SRAM one line at a time, blends them per
// colour channel with a rounded alpha weight and writes the line to the
// output buffer. Modes: 00 mix, 01 copy layer 1, 10 colour key, 11 as mix.
// Optional feature macro: ALPHA_BLEND_COLORKEY_EN builds the per-pixel key
// comparator; without it mode 10 behaves as mode 00 and key_color is ignored.
module alpha_blend_engine #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int SRC1_BASE       = 0,
    parameter int SRC2_BASE       = 65536,
    parameter int DST_BASE        = 143360,
    parameter int NUM_PIXELS      = 65536,
    parameter int ALPHA_BITS      = 4,
    parameter int ALPHA_MAX       = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alpha_en,
    input  logic [ALPHA_BITS-1:0]        alpha_value,
    input  logic [1:0]                   mode,
    input  logic [8*WORD_SIZE_BYTES-1:0] key_color,
    output logic                         alpha_busy,
    output logic                         alpha_done,
    alpha_blend_engine_if.master         mem
);
    localparam int PIX_BITS  = 8 * WORD_SIZE_BYTES;
    localparam int LINE_BITS = PIX_BITS * DATA_SIZE_WORDS;
    localparam int MIX_W     = 8 + ALPHA_BITS + 1;
    localparam int OFF_W     = $clog2(NUM_PIXELS + 1);

    localparam logic [ALPHA_BITS-1:0] ALPHA_MAX_A = ALPHA_BITS'(ALPHA_MAX);
    localparam logic [MIX_W-1:0]      ALPHA_MAX_M = MIX_W'(ALPHA_MAX);
    localparam logic [MIX_W-1:0]      ALPHA_HALF  = MIX_W'(ALPHA_MAX / 2);
    localparam logic [OFF_W-1:0]      LINE_STEP   = OFF_W'(DATA_SIZE_WORDS);
    localparam logic [OFF_W-1:0]      FRAME_END   = OFF_W'(NUM_PIXELS);
    localparam logic [1:0]            MODE_COPY   = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        BLEND,
        WR,
        DONE
    } state_t;

    state_t                  state_reg;
    logic [OFF_W-1:0]        offset_reg;
    logic [OFF_W-1:0]        offset_next;
    logic [ALPHA_BITS-1:0]   alpha_reg;
    logic [1:0]              mode_reg;
    logic [LINE_BITS-1:0]    data1_reg;
    logic [LINE_BITS-1:0]    data2_reg;
    logic [LINE_BITS-1:0]    write_data_reg;
    logic [LINE_BITS-1:0]    blend_next;
    logic [DATA_SIZE_WORDS-1:0] key_hit;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    read_enable_next;
    logic                    write_enable_next;
    logic [ADDR_SIZE_BITS-1:0] address_next;

    assign offset_next = offset_reg + LINE_STEP;

`ifdef ALPHA_BLEND_COLORKEY_EN
    localparam logic [1:0] MODE_KEY = 2'b10;
    logic [PIX_BITS-1:0] key_reg;

    // Per-pixel transparency test against the latched key colour.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_SIZE_WORDS; gi++) begin : g_key
            assign key_hit[gi] = (mode_reg == MODE_KEY) &&
                                 (data1_reg[gi*PIX_BITS +: PIX_BITS] == key_reg);
        end
    endgenerate
`else
    logic unused_key;
    assign unused_key = ^key_color;
    assign key_hit    = '0;
`endif

    // Per-channel blend: rounded weighted mean, copy, or key substitution.
    genvar gp, gb;
    generate
        for (gp = 0; gp < DATA_SIZE_WORDS; gp++) begin : g_pix
            for (gb = 0; gb < WORD_SIZE_BYTES; gb++) begin : g_byte
                localparam int B = (gp * WORD_SIZE_BYTES + gb) * 8;
                logic [MIX_W-1:0] c1;
                logic [MIX_W-1:0] c2;
                logic [MIX_W-1:0] mix_sum;
                logic [7:0]       mix_byte;
                assign c1       = MIX_W'(data1_reg[B +: 8]);
                assign c2       = MIX_W'(data2_reg[B +: 8]);
                assign mix_sum  = c1 * MIX_W'(alpha_reg)
                                + c2 * (ALPHA_MAX_M - MIX_W'(alpha_reg))
                                + ALPHA_HALF;
                assign mix_byte = 8'(mix_sum / ALPHA_MAX_M);
                assign blend_next[B +: 8] = (mode_reg == MODE_COPY) ? data1_reg[B +: 8] :
                                            key_hit[gp]             ? data2_reg[B +: 8] :
                                                                      mix_byte;
            end
        end
    endgenerate

    // Request decode from registered state and offset only; idle bus reads 0.
    always_comb begin
        read_enable_next  = 1'b0;
        write_enable_next = 1'b0;
        address_next      = '0;
        case (state_reg)
            RD1: begin
                read_enable_next = 1'b1;
                address_next     = ADDR_SIZE_BITS'(SRC1_BASE) + ADDR_SIZE_BITS'(offset_reg);
            end
            RD2: begin
                read_enable_next = 1'b1;
                address_next     = ADDR_SIZE_BITS'(SRC2_BASE) + ADDR_SIZE_BITS'(offset_reg);
            end
            WR: begin
                write_enable_next = 1'b1;
                address_next      = ADDR_SIZE_BITS'(DST_BASE) + ADDR_SIZE_BITS'(offset_reg);
            end
            default: ;
        endcase
    end

    assign mem.read_enable  = read_enable_next;
    assign mem.write_enable = write_enable_next;
    assign mem.address      = address_next;
    assign mem.write_data   = write_data_reg;
    assign alpha_busy       = busy_reg;
    assign alpha_done       = done_reg;

    // Frame sequencer: read line(s), blend, write back, advance the offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            offset_reg     <= '0;
            alpha_reg      <= '0;
            mode_reg       <= '0;
            data1_reg      <= '0;
            data2_reg      <= '0;
            write_data_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef ALPHA_BLEND_COLORKEY_EN
            key_reg        <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    offset_reg <= '0;
                    if (alpha_en) begin
                        alpha_reg <= (alpha_value > ALPHA_MAX_A) ? ALPHA_MAX_A : alpha_value;
                        mode_reg  <= mode;
`ifdef ALPHA_BLEND_COLORKEY_EN
                        key_reg   <= key_color;
`endif
                        busy_reg  <= 1'b1;
                        state_reg <= RD1;
                    end
                end
                RD1: begin
                    if (mem.mem_ready) begin
                        data1_reg <= mem.read_data;
                        state_reg <= (mode_reg == MODE_COPY) ? BLEND : RD2;
                    end
                end
                RD2: begin
                    if (mem.mem_ready) begin
                        data2_reg <= mem.read_data;
                        state_reg <= BLEND;
                    end
                end
                BLEND: begin
                    write_data_reg <= blend_next;
                    state_reg      <= WR;
                end
                WR: begin
                    if (mem.mem_ready) begin
                        offset_reg <= offset_next;
                        if (offset_next == FRAME_END) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= RD1;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alpha_blend_engine.sv
// tb_alpha_blend_engine
// Directed-vector bench for alpha_blend_engine with a two-line frame and a
// behavioural SRAM responder that can stall every request. Expected outputs
// are hand-derived constants or copies of the source patterns they must equal.
// Honours ALPHA_BLEND_COLORKEY_EN for the colour-key expectation.
module tb_alpha_blend_engine;
    localparam int AW   = 24;
    localparam int WB   = 3;
    localparam int DW   = 64;
    localparam int NP   = 128;
    localparam int PB   = 8 * WB;
    localparam int LB   = PB * DW;
    localparam int SRC1 = 0;
    localparam int SRC2 = 65536;
    localparam int DST  = 143360;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alpha_en = 1'b0;
    logic [3:0]  alpha_value = '0;
    logic [1:0]  mode = '0;
    logic [23:0] key_color = '0;
    logic        alpha_busy;
    logic        alpha_done;

    alpha_blend_engine_if #(.ADDR_SIZE_BITS(AW), .WORD_SIZE_BYTES(WB), .DATA_SIZE_WORDS(DW)) bus ();

    alpha_blend_engine #(
        .ADDR_SIZE_BITS(AW), .WORD_SIZE_BYTES(WB), .DATA_SIZE_WORDS(DW),
        .SRC1_BASE(SRC1), .SRC2_BASE(SRC2), .DST_BASE(DST),
        .NUM_PIXELS(NP), .ALPHA_BITS(4), .ALPHA_MAX(10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alpha_en    (alpha_en),
        .alpha_value (alpha_value),
        .mode        (mode),
        .key_color   (key_color),
        .alpha_busy  (alpha_busy),
        .alpha_done  (alpha_done),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [23:0] src1   [NP];
    logic [23:0] src2   [NP];
    logic [23:0] dst    [NP];
    logic [23:0] exp_px [NP];
    logic [LB-1:0] rd_line;
    int stall_n    = 0;
    int wait_cnt   = 0;
    int src2_reads = 0;
    int rd_q[$];
    int wr_q[$];
    logic [AW-1:0] lat_addr;
    logic [1:0]    lat_en;

    function automatic logic [23:0] ramp_px(input int i);
        int b;
        b = 3 * (i % DW);
        return {8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    // SRAM responder: stalls each request stall_n cycles, then serves it.
    always @(negedge clk) begin
        if (rst) begin
            bus.mem_ready = 1'b0;
            wait_cnt      = 0;
        end else if (bus.read_enable || bus.write_enable) begin
            check_val("rd_wr_exclusive", 64'(bus.read_enable & bus.write_enable), 64'd0);
            if (wait_cnt > 0) begin
                check_val("stall_addr_hold", 64'(bus.address), 64'(lat_addr));
                check_val("stall_en_hold", 64'({bus.read_enable, bus.write_enable}), 64'(lat_en));
            end else begin
                lat_addr = bus.address;
                lat_en   = {bus.read_enable, bus.write_enable};
            end
            if (wait_cnt < stall_n) begin
                bus.mem_ready = 1'b0;
                wait_cnt++;
            end else begin
                int a;
                bus.mem_ready = 1'b1;
                wait_cnt      = 0;
                a             = int'(bus.address);
                if (bus.read_enable) begin
                    rd_q.push_back(a);
                    if (a >= SRC2 && a < SRC2 + NP) src2_reads++;
                    for (int p = 0; p < DW; p++) begin
                        if (a >= SRC2 && a + p < SRC2 + NP)
                            rd_line[p*PB +: PB] = src2[a - SRC2 + p];
                        else if (a >= SRC1 && a + p < SRC1 + NP)
                            rd_line[p*PB +: PB] = src1[a - SRC1 + p];
                        else
                            rd_line[p*PB +: PB] = '0;
                    end
                    bus.read_data = rd_line;
                    $display("RD addr=0x%06h", a);
                end else begin
                    wr_q.push_back(a);
                    for (int p = 0; p < DW; p++)
                        if (a >= DST && a + p < DST + NP)
                            dst[a - DST + p] = bus.write_data[p*PB +: PB];
                    $display("WR addr=0x%06h pix0=0x%06h", a, bus.write_data[PB-1:0]);
                end
            end
        end else begin
            bus.mem_ready = 1'b0;
            wait_cnt      = 0;
        end
    end

    task automatic run_frame(input string tag, input logic [3:0] a, input logic [1:0] m,
                             input int stall, input int exp_cyc, input int exp_wr, input bit poke);
        int cyc;
        for (int i = 0; i < NP; i++) dst[i] = 24'hA5A5A5;
        rd_q.delete();
        wr_q.delete();
        src2_reads = 0;
        stall_n    = stall;
        @(negedge clk);
        #2;
        alpha_value = a;
        mode        = m;
        alpha_en    = 1'b1;
        @(posedge clk);
        #1;
        alpha_en    = 1'b0;
        alpha_value = 4'd1;
        mode        = 2'b01;
        key_color   = 24'h0;
        cyc = 1;
        check_val({tag, " busy_start"}, 64'(alpha_busy), 64'd1);
        while (alpha_done !== 1'b1 && cyc < 4000) begin
            alpha_en = (poke && cyc == 3);
            @(posedge clk);
            #1;
            cyc++;
        end
        alpha_en = 1'b0;
        $display("frame %s done at cycle %0d", tag, cyc);
        check_val({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check_val({tag, " busy_at_done"}, 64'(alpha_busy), 64'd1);
        @(posedge clk);
        #1;
        check_val({tag, " done_pulse"}, 64'(alpha_done), 64'd0);
        check_val({tag, " busy_idle"}, 64'(alpha_busy), 64'd0);
        check_val({tag, " wr_count"}, 64'(wr_q.size()), 64'(exp_wr));
        for (int i = 0; i < wr_q.size(); i++)
            check_val({tag, " wr_addr"}, 64'(wr_q[i]), 64'(DST + i * DW));
        for (int i = 0; i < NP; i++) begin
            check_val({tag, " pixel"}, 64'(dst[i]), 64'(exp_px[i]));
            if (dst[i] !== exp_px[i]) break;
        end
    endtask

    task automatic load_mix;
        for (int i = 0; i < NP; i++) begin
            src1[i]   = 24'hC8C8C8;   // 200
            src2[i]   = 24'h646464;   // 100
            exp_px[i] = 24'hAAAAAA;   // (200*7 + 100*3 + 5) / 10 = 170
        end
    endtask

    initial begin
        int n;
        bus.mem_ready = 1'b0;
        bus.read_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset read_enable", 64'(bus.read_enable), 64'd0);
        check_val("reset write_enable", 64'(bus.write_enable), 64'd0);
        check_val("reset address", 64'(bus.address), 64'd0);
        check_val("reset write_data", 64'(|bus.write_data), 64'd0);
        check_val("reset busy", 64'(alpha_busy), 64'd0);
        check_val("reset done", 64'(alpha_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        load_mix();
        run_frame("mix", 4'd7, 2'b00, 0, 9, 2, 1'b0);
        check_val("mix src2_reads", 64'(src2_reads), 64'd2);

        load_mix();
        run_frame("mode11", 4'd7, 2'b11, 0, 9, 2, 1'b0);

        for (int i = 0; i < NP; i++) begin
            src1[i]   = ramp_px(i);
            src2[i]   = {8'(i), 8'h80, 8'h3C};
            exp_px[i] = src2[i];
        end
        run_frame("alpha0", 4'd0, 2'b00, 0, 9, 2, 1'b0);

        for (int i = 0; i < NP; i++) exp_px[i] = src1[i];
        run_frame("alpha10", 4'd10, 2'b00, 0, 9, 2, 1'b0);
        run_frame("alpha15", 4'd15, 2'b00, 0, 9, 2, 1'b0);

        for (int i = 0; i < NP; i++) begin
            src1[i]   = 24'h373737;   // 55
            src2[i]   = 24'h373737;
            exp_px[i] = 24'h373737;
        end
        run_frame("equal55", 4'd3, 2'b00, 0, 9, 2, 1'b0);

        for (int i = 0; i < NP; i++) begin
            src1[i]   = ramp_px(i);
            src2[i]   = 24'hFFFFFF;
            exp_px[i] = src1[i];
        end
        run_frame("copy", 4'd3, 2'b01, 0, 7, 2, 1'b0);
        check_val("copy src2_reads", 64'(src2_reads), 64'd0);
        check_val("copy read_count", 64'(rd_q.size()), 64'd2);

        for (int i = 0; i < NP; i++) begin
            src1[i]   = ramp_px(i);
            src2[i]   = 24'h123456;
            exp_px[i] = src1[i];
        end
        src1[5] = 24'h00FF00;
`ifdef ALPHA_BLEND_COLORKEY_EN
        exp_px[5] = 24'h123456;
`else
        exp_px[5] = 24'h00FF00;
`endif
        key_color = 24'h00FF00;
        run_frame("colorkey", 4'd10, 2'b10, 0, 9, 2, 1'b0);

        load_mix();
        run_frame("stall3", 4'd7, 2'b00, 3, 27, 2, 1'b0);

        // Abort a frame during the first write, then restart it cleanly.
        load_mix();
        stall_n = 0;
        @(negedge clk);
        #2;
        alpha_value = 4'd7;
        mode        = 2'b00;
        alpha_en    = 1'b1;
        @(posedge clk);
        #1;
        alpha_en = 1'b0;
        n = 0;
        while (bus.write_enable !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("abort reached_wr", 64'(bus.write_enable), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort read_enable", 64'(bus.read_enable), 64'd0);
        check_val("abort write_enable", 64'(bus.write_enable), 64'd0);
        check_val("abort address", 64'(bus.address), 64'd0);
        check_val("abort write_data", 64'(|bus.write_data), 64'd0);
        check_val("abort busy", 64'(alpha_busy), 64'd0);
        check_val("abort done", 64'(alpha_done), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("abort no_request", 64'(bus.read_enable | bus.write_enable), 64'd0);
        run_frame("restart", 4'd7, 2'b00, 0, 9, 2, 1'b1);
        check_val("restart first_read", 64'(rd_q.size() > 0 ? rd_q[0] : -1), 64'(SRC1));
        repeat (3) @(posedge clk);
        #1;
        check_val("restart stays_idle", 64'(alpha_busy | bus.read_enable), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
